seq_mult_param: RTL and testbench



---
 rtl/seq_mult_param.sv | 120 ++++++++++++
 tb/tb_seq_mult_param.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier, signed/unsigned per operation, WIDTH+2 cycle latency.
// Optional macro MULT_EARLY_TERM_EN: leave CALC as soon as the remaining multiplier bits are zero.
module seq_mult_param #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   mlier,
  input  logic [WIDTH-1:0]   mcand,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] prodt,
  output logic [1:0]         dbg_state
);

  // Handshake: start is sampled only while busy=0 (IDLE, including the valid cycle);
  // busy stays high until the cycle valid pulses for one cycle with the new prodt.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] h_sft_q, h_sft_d;
  logic [WIDTH-1:0]   q_sft_q, q_sft_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic [2*WIDTH-1:0] prodt_q, prodt_d;

  logic [WIDTH-1:0]   mlier_mag;
  logic [WIDTH-1:0]   mcand_mag;
  logic               calc_done;

  // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign mlier_mag = (signed_mode && mlier[WIDTH-1]) ? (~mlier + WIDTH'(1)) : mlier;
  assign mcand_mag = (signed_mode && mcand[WIDTH-1]) ? (~mcand + WIDTH'(1)) : mcand;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    h_sft_d   = h_sft_q;
    q_sft_d   = q_sft_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    prodt_d   = prodt_q;
    calc_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          h_sft_d = {{WIDTH{1'b0}}, mcand_mag};
          q_sft_d = mlier_mag;
          cnt_d   = '0;
          neg_d   = signed_mode & (mlier[WIDTH-1] ^ mcand[WIDTH-1]);
          busy_d  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (q_sft_q[0]) acc_d = acc_q + h_sft_q;
        h_sft_d = h_sft_q << 1;
        q_sft_d = q_sft_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
`ifdef MULT_EARLY_TERM_EN
        calc_done = (cnt_q == CNT_W'(WIDTH - 1)) || (q_sft_d == '0);
`else
        calc_done = (cnt_q == CNT_W'(WIDTH - 1));
`endif
        if (calc_done) state_d = S_FIX;
      end
      S_FIX: begin
        // A zero magnitude stays zero, so no negative-zero encoding can appear.
        prodt_d = (neg_q && (acc_q != '0)) ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      h_sft_q <= '0;
      q_sft_q <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      prodt_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      h_sft_q <= h_sft_d;
      q_sft_q <= q_sft_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      prodt_q <= prodt_d;
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign prodt     = prodt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param: arithmetic reference model feeds an expected queue, a negedge monitor checks.
// Honors MULT_EARLY_TERM_EN when computing expected latency.
module tb_seq_mult_param;

  localparam int W = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic             signed_mode;
  logic [W-1:0]     mlier;
  logic [W-1:0]     mcand;
  logic             busy;
  logic             valid;
  logic [2*W-1:0]   prodt;
  logic [1:0]       dbg_state;

  seq_mult_param #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .mlier       (mlier),
    .mcand       (mcand),
    .busy        (busy),
    .valid       (valid),
    .prodt       (prodt),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] exp_q[$];
  int             exp_edge_q[$];
  int             edge_cnt  = 0;
  int             free_edge = 0;
  int             busy_from = 0;
  int             busy_to   = 0;
  logic [2*W-1:0] last_prodt = '0;
  bit             mon_en = 1'b0;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, act, exp);
    end
  endtask

  // reference model: exact product from plain integer arithmetic
  function automatic logic [2*W-1:0] ref_product(input bit sm, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    logic [2*W-1:0]        ua;
    logic [2*W-1:0]        ub;
    if (sm) begin
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
    end
    ua = {{W{1'b0}}, a};
    ub = {{W{1'b0}}, b};
    return ua * ub;
  endfunction

  // edges from acceptance to the edge after which valid is high
  function automatic int ref_latency(input bit sm, input logic [W-1:0] a);
`ifdef MULT_EARLY_TERM_EN
    logic [W-1:0] mag;
    int           m;
    mag = (sm && a[W-1]) ? (~a + 1'b1) : a;
    m = 0;
    for (int i = 0; i < W; i++) if (mag[i]) m = i + 1;
    return ((m < 1) ? 1 : m) + 1;
`else
    return W + 1;
`endif
  endfunction

  // acceptance model: one operation at a time, next start taken the edge after valid's edge
  always @(posedge clock) begin
    int lat;
    edge_cnt = edge_cnt + 1;
    if (!reset && start && edge_cnt >= free_edge) begin
      lat = ref_latency(signed_mode, mlier);
      exp_q.push_back(ref_product(signed_mode, mlier, mcand));
      exp_edge_q.push_back(edge_cnt + lat);
      busy_from = edge_cnt;
      busy_to   = edge_cnt + lat;
      free_edge = edge_cnt + lat + 1;
    end
  end

  // scoreboard monitor
  always @(negedge clock) begin
    logic           ev;
    logic [2*W-1:0] e;
    if (mon_en && !reset) begin
      ev = (exp_edge_q.size() > 0) && (exp_edge_q[0] == edge_cnt);
      check("valid", {{(2*W-1){1'b0}}, valid}, {{(2*W-1){1'b0}}, ev});
      check("busy", {{(2*W-1){1'b0}}, busy},
            {{(2*W-1){1'b0}}, (edge_cnt >= busy_from && edge_cnt < busy_to)});
      if (ev) begin
        e = exp_q.pop_front();
        void'(exp_edge_q.pop_front());
        check("prodt", prodt, e);
        last_prodt = e;
      end else begin
        check("prodt_hold", prodt, last_prodt);
      end
    end
  end

  // driver tasks
  task automatic issue(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    start = 1'b1; signed_mode = sm; mlier = a; mcand = b;
    @(negedge clock);
    start = 1'b0; signed_mode = 1'($urandom); mlier = $urandom; mcand = $urandom;
  endtask

  task automatic wait_free();
    int guard = 0;
    while (edge_cnt < free_edge && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 200) check("wait_free_timeout", 64'(guard), 64'(0));
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return {1'b1, {(W-1){1'b0}}};
      4: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; mlier = '0; mcand = '0;
    #1;
    check("reset_busy", {{(2*W-1){1'b0}}, busy}, '0);
    check("reset_valid", {{(2*W-1){1'b0}}, valid}, '0);
    check("reset_prodt", prodt, '0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    mon_en = 1'b1;

    // directed corner products
    issue(1'b0, 32'd3, 32'd5);                   wait_free();
    issue(1'b1, 32'hFFFF_FFF9, 32'd6);           wait_free();
    issue(1'b1, 32'hFFFF_FFFF, 32'd0);           wait_free();
    issue(1'b1, 32'h8000_0000, 32'h8000_0000);   wait_free();
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   wait_free();
    issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   wait_free();

    // start while busy must be ignored
    issue(1'b0, 32'd7, 32'd9);
    repeat (8) @(negedge clock);
    start = 1'b1; signed_mode = 1'b0; mlier = 32'd2; mcand = 32'd2;
    @(negedge clock);
    start = 1'b0;
    wait_free();

    // asynchronous reset mid-operation
    issue(1'b0, 32'd100, 32'd200);
    repeat (13) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midreset_busy", {{(2*W-1){1'b0}}, busy}, '0);
    check("midreset_valid", {{(2*W-1){1'b0}}, valid}, '0);
    check("midreset_prodt", prodt, '0);
    exp_q.delete(); exp_edge_q.delete();
    busy_to = 0; free_edge = 0; last_prodt = '0;
    @(negedge clock);
    reset = 1'b0;
    issue(1'b1, 32'hFFFF_FFF0, 32'd1000);        wait_free();

    // start held high: back-to-back acceptance in the valid cycle
    @(negedge clock);
    start = 1'b1; signed_mode = 1'b0; mlier = 32'd4; mcand = 32'd4;
    repeat (3 * (W + 2) + 2) @(negedge clock);
    start = 1'b0;
    wait_free();

    // randomized operations with occasional ignored starts
    for (int n = 0; n < 40; n++) begin
      issue(1'($urandom), rand_operand(), rand_operand());
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 10)) @(negedge clock);
        start = 1'b1; signed_mode = 1'($urandom); mlier = $urandom; mcand = $urandom;
        @(negedge clock);
        start = 1'b0;
      end
      wait_free();
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    wait_free();
    repeat (3) @(negedge clock);
    check("drain", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
